fp_to_int: RTL

Multi-cycle converter from IEEE-754 single-precision to signed 32-bit two's-complement integer. It is the inverse companion of the floating-point add/sub datapath: it denormalizes a float into an integer, where the adder normalizes aligned mantissas into a float. It uses an iterative one-bit-per-cycle shifter behind valid/ready handshakes on both sides. It sits between float results and integer consumers such as address generation and fixed-point stages.

---
 rtl/fp_pkg.sv | 20 ++
 rtl/fp_to_int_classify.sv | 68 ++++++
 rtl/fp_to_int.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared constants, FSM states and operand classes for the float-to-integer converter.
package fp_pkg;
  localparam int FP_BIAS   = 127;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  localparam int FP_INT_W  = 32;

  // Biased-exponent landmarks: 0.5, 1.0, unit lsb (no shift), and |x| >= 2^31
  localparam logic [FP_EXP_W-1:0] E_HALF = FP_EXP_W'(FP_BIAS - 1);
  localparam logic [FP_EXP_W-1:0] E_ONE  = FP_EXP_W'(FP_BIAS);
  localparam logic [FP_EXP_W-1:0] E_UNIT = FP_EXP_W'(FP_BIAS + FP_MANT_W);
  localparam logic [FP_EXP_W-1:0] E_SAT  = FP_EXP_W'(FP_BIAS + FP_INT_W - 1);
  localparam logic [FP_EXP_W-1:0] E_MAX  = '1;

  localparam logic [FP_INT_W-1:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [FP_INT_W-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} fsm_t;
  typedef enum logic [2:0] {CLS_ZERO, CLS_SPECIAL, CLS_OVF, CLS_LEFT, CLS_RIGHT} fp_class_t;
endpackage

// File: rtl/fp_to_int_classify.sv
// Combinational exponent decode: class, shift direction/count and early result for N = 0 cases.
// FP_TO_INT_ROUND_EN routes e = 126 through a 24-step right shift so it can round to 1.
module fp_to_int_classify
  import fp_pkg::*;
#(
  parameter logic [FP_INT_W-1:0] NAN_VALUE = 32'h7FFF_FFFF
) (
  input  logic [FP_INT_W-1:0] a,
  output fp_class_t           cls,
  output logic                dir_left,
  output logic [4:0]          n,
  output logic [FP_INT_W-1:0] mag,
  output logic [FP_INT_W-1:0] early_res,
  output logic                early_ovf,
  output logic                early_inx
);
  logic                 s;
  logic [FP_EXP_W-1:0]  e;
  logic [FP_MANT_W-1:0] m;

  assign s = a[FP_INT_W-1];
  assign e = a[FP_INT_W-2 -: FP_EXP_W];
  assign m = a[FP_MANT_W-1:0];

  always_comb begin
    cls       = CLS_ZERO;
    dir_left  = 1'b0;
    n         = '0;
    mag       = '0;
    early_res = '0;
    early_ovf = 1'b0;
    early_inx = |a[FP_INT_W-2:0];
    if (e == E_MAX) begin
      cls       = CLS_SPECIAL;
      early_ovf = 1'b1;
      early_inx = 1'b0;
      early_res = (m != '0) ? NAN_VALUE : (s ? INT_MIN : INT_MAX);
    end else if (e >= E_SAT) begin
      cls       = CLS_OVF;
      early_inx = 1'b0;
      // -2^31 is the one value at this magnitude that is representable
      if (s && e == E_SAT && m == '0) begin
        early_res = INT_MIN;
      end else begin
        early_ovf = 1'b1;
        early_res = s ? INT_MIN : INT_MAX;
      end
    end else if (e >= E_UNIT) begin
      cls       = CLS_LEFT;
      dir_left  = 1'b1;
      n         = 5'(e - E_UNIT);
      mag       = {{(FP_INT_W-FP_MANT_W-1){1'b0}}, 1'b1, m};
      early_inx = 1'b0;
    end else if (e >= E_ONE) begin
      cls       = CLS_RIGHT;
      n         = 5'(E_UNIT - e);
      mag       = {{(FP_INT_W-FP_MANT_W-1){1'b0}}, 1'b1, m};
      early_inx = 1'b0;
`ifdef FP_TO_INT_ROUND_EN
    end else if (e == E_HALF) begin
      cls       = CLS_RIGHT;
      n         = 5'd24;
      mag       = {{(FP_INT_W-FP_MANT_W-1){1'b0}}, 1'b1, m};
      early_inx = 1'b0;
`endif
    end
  end
endmodule

// File: rtl/fp_to_int.sv
// IEEE-754 single to int32 converter, one shift bit per cycle behind valid/ready.
// Define FP_TO_INT_ROUND_EN for round-to-nearest-even; default truncates toward zero.
module fp_to_int
  import fp_pkg::*;
#(
  parameter logic [FP_INT_W-1:0] NAN_VALUE = 32'h7FFF_FFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FP_INT_W-1:0] a,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FP_INT_W-1:0] out_data,
  output logic                ovf,
  output logic                inexact
);
  fsm_t                state_q, state_d;
  fp_class_t           c_cls;
  logic                c_dir, c_ovf, c_inx;
  logic [4:0]          c_n;
  logic [FP_INT_W-1:0] c_mag, c_res;

  logic [FP_INT_W-1:0] mag_q, sh_mag;
  logic                guard_q, sticky_q, dir_q, neg_q, sh_g, sh_s;
  logic [4:0]          cnt_q;

  logic [FP_INT_W-1:0] f_mag, f_abs, f_int, res_d;
  logic                f_g, f_s, f_neg, rnd, ovf_d, inx_d;
  logic                accept, load;

  fp_to_int_classify #(.NAN_VALUE(NAN_VALUE)) u_cls (
    .a         (a),
    .cls       (c_cls),
    .dir_left  (c_dir),
    .n         (c_n),
    .mag       (c_mag),
    .early_res (c_res),
    .early_ovf (c_ovf),
    .early_inx (c_inx)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  // Result is captured straight from the decoder when N = 0, else on the last shift
  assign load      = (accept && c_n == '0) || (state_q == SHIFT && cnt_q == 5'd1);

  always_comb begin
    sh_mag = dir_q ? {mag_q[FP_INT_W-2:0], 1'b0} : {1'b0, mag_q[FP_INT_W-1:1]};
    sh_g   = dir_q ? guard_q  : mag_q[0];
    sh_s   = dir_q ? sticky_q : (sticky_q | guard_q);
  end

  always_comb begin
    f_mag = sh_mag;
    f_g   = sh_g;
    f_s   = sh_s;
    f_neg = neg_q;
    if (state_q == IDLE) begin
      f_mag = c_mag;
      f_g   = 1'b0;
      f_s   = 1'b0;
      f_neg = a[FP_INT_W-1];
    end
    rnd = 1'b0;
`ifdef FP_TO_INT_ROUND_EN
    rnd = f_g & (f_s | f_mag[0]);
`endif
    f_abs = f_mag + {{(FP_INT_W-1){1'b0}}, rnd};
    f_int = f_neg ? -f_abs : f_abs;
    res_d = f_int;
    ovf_d = 1'b0;
    inx_d = f_g | f_s;
    if (state_q == IDLE) begin
      inx_d = c_inx;
      if (c_cls == CLS_SPECIAL || c_cls == CLS_OVF) begin
        res_d = c_res;
        ovf_d = c_ovf;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (c_n == '0) ? DONE : SHIFT;
      SHIFT:   if (cnt_q == 5'd1) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      mag_q    <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      dir_q    <= 1'b0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      out_data <= '0;
      ovf      <= 1'b0;
      inexact  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mag_q    <= c_mag;
        guard_q  <= 1'b0;
        sticky_q <= 1'b0;
        cnt_q    <= c_n;
        dir_q    <= c_dir;
        neg_q    <= a[FP_INT_W-1];
      end else if (state_q == SHIFT) begin
        mag_q    <= sh_mag;
        guard_q  <= sh_g;
        sticky_q <= sh_s;
        cnt_q    <= cnt_q - 5'd1;
      end
      if (load) begin
        out_data <= res_d;
        ovf      <= ovf_d;
        inexact  <= inx_d;
      end
    end
  end
endmodule
